rf_port_scheduler: RTL
======================

RF_PORT_SCHEDULER -- requirements
Module: rf_port_scheduler

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of register-file rows.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width.
REQ-003 SHALL have parameter DATA_W, default 16, register width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_req  input  3  read request, one bit per requester 0..2.
REQ-007 SHALL have port rd_addr  input  3*ADDR_W  read addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_gnt  output  3  read grant, combinational, same cycle as request.
REQ-009 SHALL have port rd_rsp_valid  output  3  registered read response valid, per requester.
REQ-010 SHALL have port rd_rsp_data  output  3*DATA_W  registered read data, per requester.
REQ-011 SHALL have port wr_req  input  2  write request, writers 0..1.
REQ-012 SHALL have port wr_addr  input  2*ADDR_W  write addresses.
REQ-013 SHALL have port wr_data  input  2*DATA_W  write data.
REQ-014 SHALL have port wr_gnt  output  2  write grant, combinational.
REQ-015 SHALL have port ReadEnable1 / ReadEnable2  output  NUM_REGS each  registered one-hot row select for bitline 1 / bitline 2.
REQ-016 SHALL have port WriteEnable  output  NUM_REGS  registered one-hot row write select.
REQ-017 SHALL have port D  output  DATA_W  registered write data to all rows.
REQ-018 SHALL have port Bitline1 / Bitline2  input  DATA_W each  row read data; Z when no row selected.

Function
REQ-019 SHALL grant up to two read requesters per cycle, round-robin from pointer ptr (0..2): first requester found scanning ptr, ptr+1, ptr+2 (mod 3) gets port 1, second gets port 2.
REQ-020 SHALL update ptr to (index of last granted requester + 1) mod 3; with no grant, ptr holds.
REQ-021 SHALL pipeline reads: grant cycle N registers the addresses; cycle N+1 drives the one-hot ReadEnable1/2 and samples Bitline1/2 at the N+1 edge; cycle N+2 asserts rd_rsp_valid[i] for exactly one cycle.
REQ-022 SHALL keep ReadEnable1/2 all-zero in cycles with no granted read on that port, and SHALL never sample an unselected bitline into a valid response.
REQ-023 SHALL grant writes with fixed priority, writer 0 over writer 1, one per cycle; WriteEnable and D are registered at the N+1 edge, so the cell updates at the N+2 edge.
REQ-024 SHALL treat address 0 as hardwired zero: a write to address 0 is granted but leaves WriteEnable all-zero; a read of address 0 returns 0.
REQ-025 SHALL bypass: if a read's ReadEnable cycle coincides with WriteEnable for the same nonzero row, the response carries D instead of the bitline value.
REQ-026 SHALL accept simultaneous reads and writes every cycle with no stall; responses have no back-pressure.
REQ-027 SHALL return data in rd_rsp_data slice i, which holds its value until the next valid response for requester i.
REQ-028 SHALL allow the same register to be read on both ports in one cycle.

Reset
REQ-029 SHALL, when rst is low, immediately clear ptr, all ReadEnable, WriteEnable, D, rd_rsp_valid and rd_rsp_data to 0.
REQ-030 SHALL drop all in-flight reads and writes on reset, with no response and no write after rst deasserts.
REQ-031 SHALL hold rd_gnt and wr_gnt at 0 while rst is low.

Structure
REQ-032 SHALL take NUM_REGS, ADDR_W, DATA_W, NUM_RD_REQ=3 and NUM_WR_REQ=2 from shared package rf_pkg.
REQ-033 SHALL implement address-to-one-hot decode in sub-module rf_wordline_decoder, instantiated three times (read port 1, read port 2, write).

Verification
REQ-034 SHALL cover: writer 0 writes 0xBEEF to R5 in cycle 0, requester 0 reads R5 in cycle 2 -> rd_rsp_valid[0]=1 in cycle 4 with data 0xBEEF.
REQ-035 SHALL cover: all 3 readers request for 3 cycles from reset -> grant sets {0,1},{2,0},{1,2}.
REQ-036 SHALL cover: wr_req=2'b11 at R3/R4 -> wr_gnt=2'b01; R4 written only in the next cycle.
REQ-037 SHALL cover: write 0x1234 to R7 granted at N, read R7 granted at N -> response is 0x1234 via bypass.
REQ-038 SHALL cover: write 0xFFFF to R0, then read R0 -> WriteEnable stays 0 and response is 0x0000.
REQ-039 SHALL cover: rst low in the cycle after a read grant -> no rd_rsp_valid afterwards and all outputs 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizing and round-robin helper for the register-file port scheduler
package rf_pkg;
  localparam int NUM_REGS   = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_RD_REQ = 3;
  localparam int NUM_WR_REQ = 2;

  typedef logic [1:0] rd_idx_t;

  function automatic rd_idx_t rr_wrap(input rd_idx_t base, input int step);
    int sum;
    sum = int'(base) + step;
    return rd_idx_t'(sum % NUM_RD_REQ);
  endfunction
endpackage

// File: rtl/rf_wordline_decoder.sv
// rtl/rf_wordline_decoder.sv - address to one-hot row select; row 0 is never selected
module rf_wordline_decoder
  import rf_pkg::*;
#(
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int ADDR_W   = rf_pkg::ADDR_W
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] row_sel
);
  always_comb begin
    row_sel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (en && addr == ADDR_W'(i)) row_sel[i] = 1'b1;
    end
  end
endmodule

// File: rtl/rf_port_scheduler.sv
// rtl/rf_port_scheduler.sv - 3-reader/2-writer arbiter and pipeline for a 2R1W register file
module rf_port_scheduler
  import rf_pkg::*;
#(
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int DATA_W   = rf_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD_REQ-1:0]        rd_req,
  input  logic [NUM_RD_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD_REQ-1:0]        rd_gnt,
  output logic [NUM_RD_REQ-1:0]        rd_rsp_valid,
  output logic [NUM_RD_REQ*DATA_W-1:0] rd_rsp_data,
  input  logic [NUM_WR_REQ-1:0]        wr_req,
  input  logic [NUM_WR_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_WR_REQ-1:0]        wr_gnt,
  output logic [NUM_REGS-1:0]          ReadEnable1,
  output logic [NUM_REGS-1:0]          ReadEnable2,
  output logic [NUM_REGS-1:0]          WriteEnable,
  output logic [DATA_W-1:0]            D,
  input  logic [DATA_W-1:0]            Bitline1,
  input  logic [DATA_W-1:0]            Bitline2
);
  rd_idx_t ptr, ptr_next, idx, p1_idx, p2_idx, rp_idx1, rp_idx2;
  logic p1_vld, p2_vld;
  logic [1:0] rp_vld;
  logic [ADDR_W-1:0] p1_addr, p2_addr, w_addr;
  logic [DATA_W-1:0] w_data, rd1_data, rd2_data;
  logic [NUM_REGS-1:0] re1_next, re2_next, we_next;
  logic wr_any;

  // Round-robin scan: first hit takes port 1, second hit takes port 2.
  always_comb begin
    rd_gnt   = '0;
    p1_vld   = 1'b0;
    p2_vld   = 1'b0;
    p1_idx   = '0;
    p2_idx   = '0;
    idx      = '0;
    ptr_next = ptr;
    for (int j = 0; j < NUM_RD_REQ; j++) begin
      idx = rr_wrap(ptr, j);
      if (rst && rd_req[idx]) begin
        if (!p1_vld) begin
          p1_vld      = 1'b1;
          p1_idx      = idx;
          rd_gnt[idx] = 1'b1;
        end else if (!p2_vld) begin
          p2_vld      = 1'b1;
          p2_idx      = idx;
          rd_gnt[idx] = 1'b1;
        end
      end
    end
    if (p2_vld)      ptr_next = rr_wrap(p2_idx, 1);
    else if (p1_vld) ptr_next = rr_wrap(p1_idx, 1);
  end

  assign p1_addr = rd_addr[p1_idx*ADDR_W +: ADDR_W];
  assign p2_addr = rd_addr[p2_idx*ADDR_W +: ADDR_W];

  assign wr_gnt[0] = rst & wr_req[0];
  assign wr_gnt[1] = rst & wr_req[1] & ~wr_req[0];
  assign wr_any    = |wr_gnt;
  assign w_addr    = wr_gnt[0] ? wr_addr[0 +: ADDR_W] : wr_addr[ADDR_W +: ADDR_W];
  assign w_data    = wr_gnt[0] ? wr_data[0 +: DATA_W] : wr_data[DATA_W +: DATA_W];

  rf_wordline_decoder #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_dec_rd1 (
    .en(p1_vld), .addr(p1_addr), .row_sel(re1_next));
  rf_wordline_decoder #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_dec_rd2 (
    .en(p2_vld), .addr(p2_addr), .row_sel(re2_next));
  rf_wordline_decoder #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_dec_wr (
    .en(wr_any), .addr(w_addr), .row_sel(we_next));

  // A granted read with no row selected is address 0; a row colliding with the write takes D.
  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    if (|(ReadEnable1 & WriteEnable)) rd1_data = D;
    else if (|ReadEnable1)            rd1_data = Bitline1;
    if (|(ReadEnable2 & WriteEnable)) rd2_data = D;
    else if (|ReadEnable2)            rd2_data = Bitline2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      ReadEnable1  <= '0;
      ReadEnable2  <= '0;
      WriteEnable  <= '0;
      D            <= '0;
      rp_vld       <= '0;
      rp_idx1      <= '0;
      rp_idx2      <= '0;
      rd_rsp_valid <= '0;
      rd_rsp_data  <= '0;
    end else begin
      ptr         <= ptr_next;
      ReadEnable1 <= re1_next;
      ReadEnable2 <= re2_next;
      WriteEnable <= we_next;
      if (wr_any) D <= w_data;
      rp_vld  <= {p2_vld, p1_vld};
      rp_idx1 <= p1_idx;
      rp_idx2 <= p2_idx;
      for (int i = 0; i < NUM_RD_REQ; i++) begin
        rd_rsp_valid[i] <= 1'b0;
        if (rp_vld[0] && rp_idx1 == rd_idx_t'(i)) begin
          rd_rsp_valid[i]                 <= 1'b1;
          rd_rsp_data[i*DATA_W +: DATA_W] <= rd1_data;
        end else if (rp_vld[1] && rp_idx2 == rd_idx_t'(i)) begin
          rd_rsp_valid[i]                 <= 1'b1;
          rd_rsp_data[i*DATA_W +: DATA_W] <= rd2_data;
        end
      end
    end
  end
endmodule
